// File: rtl/zxw_disp_pkg.sv
// Shared types and constants for the BCD seven-segment display block:
// conversion FSM states, segment patterns and digit-anode selects.
package zxw_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Segment patterns are active-low, ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam logic [2:0] DIG_ONES  = 3'b110;
    localparam logic [2:0] DIG_TENS  = 3'b101;
    localparam logic [2:0] DIG_HUNS  = 3'b011;
    localparam logic [2:0] DIG_NONE  = 3'b111;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/zxw_seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder with blanking.
module zxw_seg7_decode
    import zxw_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (nibble_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/zxw_bcd_display.sv
// Byte-to-BCD converter (sequential double dabble) driving a multiplexed
// 3-digit common-anode seven-segment display with leading-zero blanking.
module zxw_bcd_display
    import zxw_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  Value_in,
    output logic [11:0] Bcd_out,
    output logic        Busy,
    output logic        Done,
    output logic [6:0]  Seg_out,
    output logic [2:0]  Dig_out
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    state_e      state_q, state_d;
    logic [7:0]  lastVal_q, lastVal_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  bitCnt_q, bitCnt_d;
    logic [11:0] bcdOut_q, bcdOut_d;
    logic        done_q, done_d;
    logic [19:0] dabble;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digIdx_q, digIdx_d;
    logic [6:0]    seg_q, segDec;
    logic [2:0]    dig_q, digSel;
    logic [3:0]    nibSel;
    logic          blankSel;

    always_comb begin
        state_d  = state_q;
        lastVal_d = lastVal_q;
        shreg_d  = shreg_q;
        bcd_d    = bcd_q;
        bitCnt_d = bitCnt_q;
        bcdOut_d = bcdOut_q;
        done_d   = 1'b0;
        dabble   = '0;
        case (state_q)
            IDLE: begin
                if (Value_in != lastVal_q) begin
                    shreg_d   = Value_in;
                    lastVal_d = Value_in;
                    bcd_d     = '0;
                    bitCnt_d  = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                dabble   = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0]), shreg_q} << 1;
                bcd_d    = dabble[19:8];
                shreg_d  = dabble[7:0];
                bitCnt_d = bitCnt_q + 3'd1;
                if (bitCnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcdOut_d = bcd_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            lastVal_q <= '0;
            shreg_q   <= '0;
            bcd_q     <= '0;
            bitCnt_q  <= '0;
            bcdOut_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lastVal_q <= lastVal_d;
            shreg_q   <= shreg_d;
            bcd_q     <= bcd_d;
            bitCnt_q  <= bitCnt_d;
            bcdOut_q  <= bcdOut_d;
            done_q    <= done_d;
        end
    end

    // Scan runs freely, so the display keeps showing the last committed result mid-conversion
    always_comb begin
        presc_d  = presc_q + PW'(1);
        digIdx_d = digIdx_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            case (digIdx_q)
                2'd0:    digIdx_d = 2'd1;
                2'd1:    digIdx_d = 2'd2;
                default: digIdx_d = 2'd0;
            endcase
        end else if (digIdx_q == 2'd3) begin
            digIdx_d = 2'd0;
        end
    end

    always_comb begin
        nibSel   = bcdOut_q[3:0];
        blankSel = 1'b1;
        digSel   = DIG_NONE;
        case (digIdx_q)
            2'd0: begin
                nibSel   = bcdOut_q[3:0];
                blankSel = 1'b0;
                digSel   = DIG_ONES;
            end
            2'd1: begin
                nibSel   = bcdOut_q[7:4];
                blankSel = (bcdOut_q[11:8] == 4'd0) && (bcdOut_q[7:4] == 4'd0);
                digSel   = DIG_TENS;
            end
            2'd2: begin
                nibSel   = bcdOut_q[11:8];
                blankSel = (bcdOut_q[11:8] == 4'd0);
                digSel   = DIG_HUNS;
            end
            default: begin
                nibSel   = bcdOut_q[3:0];
                blankSel = 1'b1;
                digSel   = DIG_NONE;
            end
        endcase
    end

    zxw_seg7_decode uDecode (
        .nibble_i (nibSel),
        .blank_i  (blankSel),
        .seg_o    (segDec)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            presc_q  <= '0;
            digIdx_q <= '0;
            seg_q    <= SEG_BLANK;
            dig_q    <= DIG_NONE;
        end else begin
            presc_q  <= presc_d;
            digIdx_q <= digIdx_d;
            seg_q    <= segDec;
            dig_q    <= digSel;
        end
    end

    assign Bcd_out = bcdOut_q;
    assign Busy    = (state_q == SHIFT);
    assign Done    = done_q;
    assign Seg_out = seg_q;
    assign Dig_out = dig_q;

endmodule

// File: tb/tb_zxw_bcd_display.sv
// Directed self-checking bench for zxw_bcd_display with a fast scan divider.
module tb_zxw_bcd_display;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  Value_in = 8'd0;
    logic [11:0] Bcd_out;
    logic        Busy;
    logic        Done;
    logic [6:0]  Seg_out;
    logic [2:0]  Dig_out;

    int checks = 0;
    int errors = 0;

    zxw_bcd_display #(.SCAN_DIV(4)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Value_in (Value_in),
        .Bcd_out  (Bcd_out),
        .Busy     (Busy),
        .Done     (Done),
        .Seg_out  (Seg_out),
        .Dig_out  (Dig_out)
    );

    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic waitDone(output int cycles, output bit timedOut);
        cycles   = 0;
        timedOut = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            cycles++;
            if (Done === 1'b1) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    // Records the last segment pattern seen in each digit slot over more than one scan period
    task automatic observeScan(output logic [6:0] segOnes, output logic [6:0] segTens,
                               output logic [6:0] segHuns, output bit seenAll);
        bit s0, s1, s2;
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
        segOnes = 'x; segTens = 'x; segHuns = 'x;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            case (Dig_out)
                3'b110: begin segOnes = Seg_out; s0 = 1'b1; end
                3'b101: begin segTens = Seg_out; s1 = 1'b1; end
                3'b011: begin segHuns = Seg_out; s2 = 1'b1; end
                default: ;
            endcase
        end
        seenAll = s0 & s1 & s2;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Value_in = 8'd0;
        tick();
        tick();
        checks++; if (Bcd_out !== 12'h000) begin errors++; $display("[TB] FAIL rst_bcd: got %h expected 000", Bcd_out); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %b expected 0", Done); end
        checks++; if (Dig_out !== 3'b111) begin errors++; $display("[TB] FAIL rst_dig: got %b expected 111", Dig_out); end
        checks++; if (Seg_out !== 7'b1111111) begin errors++; $display("[TB] FAIL rst_seg: got %b expected 1111111", Seg_out); end
        Reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL idle0_busy cyc%0d: got %b expected 0", i, Busy); end
            checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL idle0_done cyc%0d: got %b expected 0", i, Done); end
            if (Dig_out === 3'b110) begin
                checks++; if (Seg_out !== 7'b1000000) begin errors++; $display("[TB] FAIL idle0_ones cyc%0d: got %b expected 1000000", i, Seg_out); end
            end else begin
                checks++; if (Seg_out !== 7'b1111111) begin errors++; $display("[TB] FAIL idle0_blank cyc%0d dig %b: got %b expected 1111111", i, Dig_out, Seg_out); end
            end
        end
        checks++; if (Bcd_out !== 12'h000) begin errors++; $display("[TB] FAIL idle0_bcd: got %h expected 000", Bcd_out); end
    endtask

    task automatic test_latency_255();
        logic [6:0] so, st, sh;
        bit seen;
        logic expBusy, expDone;
        Value_in = 8'd255;
        for (int i = 0; i <= 10; i++) begin
            tick();
            expBusy = (i <= 7);
            expDone = (i == 9);
            checks++; if (Busy !== expBusy) begin errors++; $display("[TB] FAIL lat_busy edge%0d: got %b expected %b", i, Busy, expBusy); end
            checks++; if (Done !== expDone) begin errors++; $display("[TB] FAIL lat_done edge%0d: got %b expected %b", i, Done, expDone); end
            if (i == 8) begin
                checks++; if (Bcd_out !== 12'h000) begin errors++; $display("[TB] FAIL lat_bcd_old: got %h expected 000", Bcd_out); end
            end
            if (i == 9) begin
                checks++; if (Bcd_out !== 12'h255) begin errors++; $display("[TB] FAIL lat_bcd_255: got %h expected 255", Bcd_out); end
            end
        end
        observeScan(so, st, sh, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL scan255_slots: got %b expected 1", seen); end
        checks++; if (so !== 7'b0010010) begin errors++; $display("[TB] FAIL scan255_ones: got %b expected 0010010", so); end
        checks++; if (st !== 7'b0010010) begin errors++; $display("[TB] FAIL scan255_tens: got %b expected 0010010", st); end
        checks++; if (sh !== 7'b0100100) begin errors++; $display("[TB] FAIL scan255_huns: got %b expected 0100100", sh); end
    endtask

    task automatic test_blanking();
        logic [6:0] so, st, sh;
        bit seen, to;
        int cyc;
        Value_in = 8'd100;
        waitDone(cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL blank100_timeout: got %b expected 0", to); end
        checks++; if (Bcd_out !== 12'h100) begin errors++; $display("[TB] FAIL blank100_bcd: got %h expected 100", Bcd_out); end
        observeScan(so, st, sh, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL blank100_slots: got %b expected 1", seen); end
        checks++; if (so !== 7'b1000000) begin errors++; $display("[TB] FAIL blank100_ones: got %b expected 1000000", so); end
        checks++; if (st !== 7'b1000000) begin errors++; $display("[TB] FAIL blank100_tens: got %b expected 1000000", st); end
        checks++; if (sh !== 7'b1111001) begin errors++; $display("[TB] FAIL blank100_huns: got %b expected 1111001", sh); end
        Value_in = 8'd7;
        waitDone(cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL blank7_timeout: got %b expected 0", to); end
        checks++; if (Bcd_out !== 12'h007) begin errors++; $display("[TB] FAIL blank7_bcd: got %h expected 007", Bcd_out); end
        observeScan(so, st, sh, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL blank7_slots: got %b expected 1", seen); end
        checks++; if (so !== 7'b1111000) begin errors++; $display("[TB] FAIL blank7_ones: got %b expected 1111000", so); end
        checks++; if (st !== 7'b1111111) begin errors++; $display("[TB] FAIL blank7_tens: got %b expected 1111111", st); end
        checks++; if (sh !== 7'b1111111) begin errors++; $display("[TB] FAIL blank7_huns: got %b expected 1111111", sh); end
    endtask

    task automatic test_back_to_back();
        int doneCnt;
        int doneAt[4];
        logic [11:0] bcdAt[4];
        doneCnt = 0;
        for (int k = 0; k < 4; k++) begin doneAt[k] = -1; bcdAt[k] = 'x; end
        Value_in = 8'd18;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (i == 2) Value_in = 8'd200;
            if (i == 10) begin
                checks++; if (Busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart_busy: got %b expected 1", Busy); end
            end
            if (Done === 1'b1) begin
                if (doneCnt < 4) begin doneAt[doneCnt] = i; bcdAt[doneCnt] = Bcd_out; end
                doneCnt++;
            end
        end
        checks++; if (doneCnt != 2) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", doneCnt); end
        checks++; if (doneAt[0] != 9) begin errors++; $display("[TB] FAIL b2b_first_edge: got %0d expected 9", doneAt[0]); end
        checks++; if (bcdAt[0] !== 12'h018) begin errors++; $display("[TB] FAIL b2b_first_bcd: got %h expected 018", bcdAt[0]); end
        checks++; if (doneAt[1] != 19) begin errors++; $display("[TB] FAIL b2b_second_edge: got %0d expected 19", doneAt[1]); end
        checks++; if (bcdAt[1] !== 12'h200) begin errors++; $display("[TB] FAIL b2b_second_bcd: got %h expected 200", bcdAt[1]); end
    endtask

    task automatic test_reset_mid_shift();
        int cyc;
        bit to;
        Value_in = 8'd99;
        for (int i = 0; i <= 4; i++) tick();
        checks++; if (Busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", Busy); end
        Reset = 1'b1;
        tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", Done); end
        checks++; if (Bcd_out !== 12'h000) begin errors++; $display("[TB] FAIL midrst_bcd: got %h expected 000", Bcd_out); end
        checks++; if (Dig_out !== 3'b111) begin errors++; $display("[TB] FAIL midrst_dig: got %b expected 111", Dig_out); end
        checks++; if (Seg_out !== 7'b1111111) begin errors++; $display("[TB] FAIL midrst_seg: got %b expected 1111111", Seg_out); end
        Reset = 1'b0;
        waitDone(cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL midrst_timeout: got %b expected 0", to); end
        checks++; if (cyc != 10) begin errors++; $display("[TB] FAIL midrst_latency: got %0d expected 10", cyc); end
        checks++; if (Bcd_out !== 12'h099) begin errors++; $display("[TB] FAIL midrst_bcd99: got %h expected 099", Bcd_out); end
    endtask

    task automatic test_sweep();
        int cyc;
        bit to;
        logic [11:0] exp;
        for (int v = 0; v < 256; v++) begin
            Value_in = 8'(v);
            exp = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            waitDone(cyc, to);
            checks++;
            if (to) begin
                errors++; $display("[TB] FAIL sweep_timeout v=%0d: got no Done expected Done", v);
            end else if (Bcd_out !== exp) begin
                errors++; $display("[TB] FAIL sweep_bcd v=%0d: got %h expected %h", v, Bcd_out, exp);
            end
            checks++;
            if (Bcd_out[11:8] > 4'd9 || Bcd_out[7:4] > 4'd9 || Bcd_out[3:0] > 4'd9) begin
                errors++; $display("[TB] FAIL sweep_nibble v=%0d: got %h expected all nibbles <= 9", v, Bcd_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency_255();
        test_blanking();
        test_back_to_back();
        test_reset_mid_shift();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
